// File: rtl/uart_frame_sequencer_pkg.sv
// Shared types and constants for the UART frame sequencer: FSM states, field codes,
// byte phases, default header and the frame length helper.
package uart_frame_pkg;

  typedef enum logic [1:0] {IDLE, LOAD, WAIT, DONE} state_t;
  typedef enum logic [1:0] {FLD_IDX, FLD_MSB, FLD_LSB} fld_t;
  typedef enum logic [1:0] {PH_HDR, PH_DATA, PH_CHK} phase_t;

  localparam logic [7:0] HEADER_DEF = 8'hA5;

  function automatic int unsigned frame_len(input int unsigned n_ch, input bit chk_en);
    return 1 + 3 * n_ch + 32'(chk_en);
  endfunction

endpackage

// File: rtl/uart_frame_sequencer_if.sv
// Byte handshake between the frame sequencer (master) and the UART TX core (slave).
interface uart_frame_sequencer_if;
  logic       tx_start;
  logic [7:0] tx_data;
  logic       tx_done_tick;

  modport master (output tx_start, output tx_data, input tx_done_tick);
  modport slave  (input tx_start, input tx_data, output tx_done_tick);
endinterface

// File: rtl/uart_frame_sequencer_byte_sel.sv
// Combinational byte picker: header, channel index / sample MSB / sample LSB, or checksum.
module frame_byte_sel
  import uart_frame_pkg::*;
#(
  parameter int         N_CH   = 13,
  parameter int         DW     = 12,
  parameter logic [7:0] HEADER = HEADER_DEF
) (
  input  logic [N_CH-1:0][DW-1:0] snap,
  input  logic [3:0]              ch,
  input  fld_t                    fld,
  input  phase_t                  ph,
  input  logic [7:0]              chk,
  output logic [7:0]              sel_byte
);

  logic [15:0] smp;

  always_comb begin
    // Compare-based mux keeps the index legal for any N_CH, not just powers of two.
    smp = '0;
    for (int k = 0; k < N_CH; k++)
      if (ch == 4'(k)) smp = 16'(snap[k]);
    case (ph)
      PH_HDR:  sel_byte = HEADER;
      PH_DATA: begin
        case (fld)
          FLD_IDX: sel_byte = {4'h0, ch};
          FLD_MSB: sel_byte = smp[15:8];
          default: sel_byte = smp[7:0];
        endcase
      end
      default: sel_byte = chk;
    endcase
  end

endmodule

// File: rtl/uart_frame_sequencer.sv
// Sends one snapshot of all channels to the UART TX as HEADER + {idx, msb, lsb} per channel.
// Define UART_FRAME_CHECKSUM_EN to append an XOR checksum of every byte after the header.
module uart_frame_sequencer
  import uart_frame_pkg::*;
#(
  parameter int         N_CH   = 13,
  parameter int         DW     = 12,
  parameter logic [7:0] HEADER = HEADER_DEF
) (
  input  logic                   clk,
  input  logic                   reset_n,
  input  logic                   start,
  input  logic [N_CH*DW-1:0]     samples,
  uart_frame_sequencer_if.master tx,
  output logic                   busy,
  output logic                   frame_done_tick
);

`ifdef UART_FRAME_CHECKSUM_EN
  localparam bit CHK_EN = 1'b1;
`else
  localparam bit CHK_EN = 1'b0;
`endif

  state_t                  state;
  logic [N_CH-1:0][DW-1:0] snap;
  logic [3:0]              ch, adv_ch, sel_ch;
  fld_t                    fld, adv_fld, sel_fld;
  phase_t                  ph, adv_ph, sel_ph;
  logic                    last;
  logic [7:0]              chk, sel_byte;

  // Pointer step: header -> (idx,msb,lsb) x N_CH -> optional checksum.
  always_comb begin
    adv_ph  = ph;
    adv_ch  = ch;
    adv_fld = fld;
    last    = 1'b0;
    case (ph)
      PH_HDR: begin
        adv_ph  = PH_DATA;
        adv_ch  = '0;
        adv_fld = FLD_IDX;
      end
      PH_DATA: begin
        case (fld)
          FLD_IDX: adv_fld = FLD_MSB;
          FLD_MSB: adv_fld = FLD_LSB;
          default: begin
            if (ch == 4'(N_CH - 1)) begin
              adv_ph = PH_CHK;
              last   = !CHK_EN;
            end else begin
              adv_ch  = ch + 4'd1;
              adv_fld = FLD_IDX;
            end
          end
        endcase
      end
      default: last = 1'b1;
    endcase
  end

  // tx_data is registered on LOAD entry, so select the byte at the pointer being entered.
  always_comb begin
    sel_ph  = adv_ph;
    sel_ch  = adv_ch;
    sel_fld = adv_fld;
    if (state == IDLE) begin
      sel_ph  = PH_HDR;
      sel_ch  = '0;
      sel_fld = FLD_IDX;
    end
  end

  frame_byte_sel #(.N_CH(N_CH), .DW(DW), .HEADER(HEADER)) u_sel (
    .snap     (snap),
    .ch       (sel_ch),
    .fld      (sel_fld),
    .ph       (sel_ph),
    .chk      (chk),
    .sel_byte (sel_byte)
  );

`ifndef UART_FRAME_CHECKSUM_EN
  assign chk = 8'h00;
`endif

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state           <= IDLE;
      tx.tx_start     <= 1'b0;
      tx.tx_data      <= '0;
      busy            <= 1'b0;
      frame_done_tick <= 1'b0;
      snap            <= '0;
      ch              <= '0;
      fld             <= FLD_IDX;
      ph              <= PH_HDR;
`ifdef UART_FRAME_CHECKSUM_EN
      chk             <= '0;
`endif
    end else begin
      tx.tx_start     <= 1'b0;
      frame_done_tick <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            snap        <= samples;
            ch          <= '0;
            fld         <= FLD_IDX;
            ph          <= PH_HDR;
`ifdef UART_FRAME_CHECKSUM_EN
            chk         <= '0;
`endif
            busy        <= 1'b1;
            tx.tx_data  <= sel_byte;
            tx.tx_start <= 1'b1;
            state       <= LOAD;
          end
        end
        LOAD: state <= WAIT;
        WAIT: begin
          if (tx.tx_done_tick) begin
            if (last) begin
              busy            <= 1'b0;
              frame_done_tick <= 1'b1;
              state           <= DONE;
            end else begin
              ch          <= adv_ch;
              fld         <= adv_fld;
              ph          <= adv_ph;
`ifdef UART_FRAME_CHECKSUM_EN
              // Fold each data byte in as it is launched; the checksum byte reads the total.
              if (adv_ph == PH_DATA) chk <= chk ^ sel_byte;
`endif
              tx.tx_data  <= sel_byte;
              tx.tx_start <= 1'b1;
              state       <= LOAD;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_uart_frame_sequencer.sv
// Directed bench: UART model returns tx_done_tick 5 cycles after each tx_start; monitor logs bytes.
module tb_uart_frame_sequencer;

  localparam int N_CH = 13;
  localparam int DW   = 12;
`ifdef UART_FRAME_CHECKSUM_EN
  localparam int FLEN = 41;
  localparam bit CHK  = 1'b1;
`else
  localparam int FLEN = 40;
  localparam bit CHK  = 1'b0;
`endif

  logic clk = 1'b0, reset_n = 1'b0, start = 1'b0;
  logic [N_CH*DW-1:0] samples = '0;
  logic busy, frame_done_tick;

  uart_frame_sequencer_if tx();

  uart_frame_sequencer dut (
    .clk             (clk),
    .reset_n         (reset_n),
    .start           (start),
    .samples         (samples),
    .tx              (tx),
    .busy            (busy),
    .frame_done_tick (frame_done_tick)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic [7:0] bytes[$];
  logic [7:0] exp_q[$];
  int st_cyc[$];
  int dn_cyc[$];
  int fd_cnt = 0, fd_cyc = 0, cnt = 0;
  bit spur = 1'b0;
  int n_checks = 0, n_fail = 0;
  logic [DW-1:0] smp [N_CH];

  // UART model + monitor, all on the falling edge.
  initial begin
    tx.tx_done_tick = 1'b0;
    forever begin
      @(negedge clk);
      if (tx.tx_start) begin bytes.push_back(tx.tx_data); st_cyc.push_back(cyc); end
      if (frame_done_tick) begin fd_cnt++; fd_cyc = cyc; end
      tx.tx_done_tick = spur;
      if (!reset_n) cnt = 0;
      else if (cnt > 0) begin
        cnt--;
        if (cnt == 0) begin tx.tx_done_tick = 1'b1; dn_cyc.push_back(cyc); end
      end
      if (tx.tx_start && reset_n) cnt = 5;
    end
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic load_samples();
    for (int k = 0; k < N_CH; k++) samples[k*DW +: DW] = smp[k];
  endtask

  task automatic build_exp();
    logic [15:0] w;
    logic [7:0]  x;
    x = 8'h00;
    exp_q.delete();
    exp_q.push_back(8'hA5);
    for (int k = 0; k < N_CH; k++) begin
      w = 16'(smp[k]);
      exp_q.push_back({4'h0, 4'(k)});
      exp_q.push_back(w[15:8]);
      exp_q.push_back(w[7:0]);
      x = x ^ {4'h0, 4'(k)} ^ w[15:8] ^ w[7:0];
    end
    if (CHK) exp_q.push_back(x);
  endtask

  task automatic clear_mon();
    bytes.delete(); st_cyc.delete(); dn_cyc.delete(); fd_cnt = 0;
  endtask

  task automatic pulse_start(output int t);
    @(negedge clk); start = 1'b1; t = cyc;
    @(negedge clk); start = 1'b0;
  endtask

  task automatic wait_fd(input int target, input int budget, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < budget; i++) begin
      @(negedge clk);
      if (fd_cnt >= target) begin ok = 1'b1; break; end
    end
  endtask

  task automatic test_reset();
    #1;
    n_checks++; if (tx.tx_start !== 1'b0) begin n_fail++; $display("FAIL reset_tx_start got %b exp 0", tx.tx_start); end
    n_checks++; if (tx.tx_data !== 8'h00) begin n_fail++; $display("FAIL reset_tx_data got %h exp 00", tx.tx_data); end
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy got %b exp 0", busy); end
    n_checks++; if (frame_done_tick !== 1'b0) begin n_fail++; $display("FAIL reset_frame_done got %b exp 0", frame_done_tick); end
    repeat (3) @(negedge clk);
    reset_n = 1'b1;
    repeat (2) @(negedge clk);
  endtask

  task automatic test_frame();
    int t0, bad;
    bit ok;
    for (int k = 0; k < N_CH; k++) smp[k] = {4'(k), 8'hC3};
    smp[0] = 12'h123; smp[N_CH-1] = 12'hFFF;
    load_samples(); build_exp(); clear_mon();
    pulse_start(t0);
    n_checks++; if (busy !== 1'b1) begin n_fail++; $display("FAIL frame_busy_high got %b exp 1", busy); end
    wait_fd(1, 600, ok);
    repeat (3) @(negedge clk);
    n_checks++; if (!ok) begin n_fail++; $display("FAIL frame_timeout got no frame_done_tick exp one"); end
    n_checks++; if (bytes.size() !== FLEN) begin n_fail++; $display("FAIL frame_len got %0d exp %0d", bytes.size(), FLEN); end
    for (int i = 0; i < FLEN; i++) begin
      n_checks++;
      if (bytes[i] !== exp_q[i]) begin n_fail++; $display("FAIL frame_byte[%0d] got %h exp %h", i, bytes[i], exp_q[i]); end
    end
    n_checks++; if (st_cyc[0] !== t0 + 1) begin n_fail++; $display("FAIL start_latency got %0d exp %0d", st_cyc[0], t0 + 1); end
    bad = 0;
    for (int i = 1; i < st_cyc.size(); i++) if (st_cyc[i] != dn_cyc[i-1] + 1) bad++;
    n_checks++; if (bad !== 0) begin n_fail++; $display("FAIL done_to_start_latency got %0d late starts exp 0", bad); end
    n_checks++; if (fd_cnt !== 1) begin n_fail++; $display("FAIL frame_done_count got %0d exp 1", fd_cnt); end
    n_checks++; if (fd_cyc !== dn_cyc[dn_cyc.size()-1] + 1) begin n_fail++; $display("FAIL frame_done_latency got %0d exp %0d", fd_cyc, dn_cyc[dn_cyc.size()-1] + 1); end
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL frame_busy_low got %b exp 0", busy); end
  endtask

  task automatic test_restart();
    int t0, t1;
    bit ok, seen;
    for (int k = 0; k < N_CH; k++) smp[k] = 12'hA00 + 12'(k);
    load_samples(); clear_mon();
    pulse_start(t0);
    seen = 1'b0;
    for (int i = 0; i < 200 && !seen; i++) begin @(negedge clk); seen = (bytes.size() >= 7); end
    @(negedge clk); start = 1'b1;
    @(negedge clk); start = 1'b0;
    seen = 1'b0;
    for (int i = 0; i < 600 && !seen; i++) begin @(negedge clk); seen = (frame_done_tick === 1'b1); end
    // start held through the DONE cycle only
    start = 1'b1;
    @(negedge clk); start = 1'b0;
    repeat (30) @(negedge clk);
    n_checks++; if (!seen) begin n_fail++; $display("FAIL restart_timeout got no frame_done_tick exp one"); end
    n_checks++; if (bytes.size() !== FLEN) begin n_fail++; $display("FAIL restart_single_frame got %0d bytes exp %0d", bytes.size(), FLEN); end
    n_checks++; if (fd_cnt !== 1) begin n_fail++; $display("FAIL restart_done_count got %0d exp 1", fd_cnt); end
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL restart_busy got %b exp 0", busy); end

    clear_mon();
    pulse_start(t0);
    seen = 1'b0;
    for (int i = 0; i < 600 && !seen; i++) begin @(negedge clk); seen = (frame_done_tick === 1'b1); end
    @(negedge clk); start = 1'b1; t1 = cyc;
    @(negedge clk); start = 1'b0;
    wait_fd(2, 600, ok);
    repeat (3) @(negedge clk);
    n_checks++; if (!ok) begin n_fail++; $display("FAIL back_to_back_timeout got %0d frames exp 2", fd_cnt); end
    n_checks++; if (bytes.size() !== 2 * FLEN) begin n_fail++; $display("FAIL back_to_back_len got %0d exp %0d", bytes.size(), 2 * FLEN); end
    n_checks++; if (st_cyc[FLEN] !== t1 + 1) begin n_fail++; $display("FAIL back_to_back_latency got %0d exp %0d", st_cyc[FLEN], t1 + 1); end
    n_checks++; if (bytes[FLEN] !== 8'hA5) begin n_fail++; $display("FAIL back_to_back_header got %h exp a5", bytes[FLEN]); end
  endtask

  task automatic test_snapshot();
    bit ok;
    for (int k = 0; k < N_CH; k++) smp[k] = 12'h5A0 ^ 12'(k * 7);
    load_samples(); build_exp(); clear_mon();
    @(negedge clk); start = 1'b1;
    @(negedge clk); start = 1'b0; samples = '0;
    wait_fd(1, 600, ok);
    repeat (3) @(negedge clk);
    n_checks++; if (!ok || bytes.size() !== FLEN) begin n_fail++; $display("FAIL snapshot_len got %0d exp %0d", bytes.size(), FLEN); end
    for (int i = 0; i < FLEN; i++) begin
      n_checks++;
      if (bytes[i] !== exp_q[i]) begin n_fail++; $display("FAIL snapshot_byte[%0d] got %h exp %h", i, bytes[i], exp_q[i]); end
    end
  endtask

  task automatic test_reset_mid();
    int t0;
    bit ok, seen;
    for (int k = 0; k < N_CH; k++) smp[k] = 12'h3C0 + 12'(k);
    load_samples(); build_exp(); clear_mon();
    pulse_start(t0);
    seen = 1'b0;
    for (int i = 0; i < 400 && !seen; i++) begin @(negedge clk); seen = (bytes.size() >= 20); end
    @(negedge clk); reset_n = 1'b0;
    #1;
    n_checks++; if (!seen) begin n_fail++; $display("FAIL reset_mid_reach got %0d bytes exp 20", bytes.size()); end
    n_checks++; if (tx.tx_start !== 1'b0) begin n_fail++; $display("FAIL reset_mid_tx_start got %b exp 0", tx.tx_start); end
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_mid_busy got %b exp 0", busy); end
    n_checks++; if (tx.tx_data !== 8'h00) begin n_fail++; $display("FAIL reset_mid_tx_data got %h exp 00", tx.tx_data); end
    repeat (3) @(negedge clk);
    reset_n = 1'b1;
    repeat (10) @(negedge clk);
    n_checks++; if (fd_cnt !== 0) begin n_fail++; $display("FAIL reset_mid_no_done got %0d exp 0", fd_cnt); end
    clear_mon();
    pulse_start(t0);
    wait_fd(1, 600, ok);
    repeat (3) @(negedge clk);
    n_checks++; if (!ok || bytes.size() !== FLEN) begin n_fail++; $display("FAIL reset_mid_refrm_len got %0d exp %0d", bytes.size(), FLEN); end
    n_checks++; if (bytes[0] !== 8'hA5) begin n_fail++; $display("FAIL reset_mid_header got %h exp a5", bytes[0]); end
    n_checks++; if (bytes[FLEN-1] !== exp_q[FLEN-1]) begin n_fail++; $display("FAIL reset_mid_last got %h exp %h", bytes[FLEN-1], exp_q[FLEN-1]); end
  endtask

  task automatic test_spurious();
    clear_mon();
    @(negedge clk); spur = 1'b1;
    repeat (3) @(negedge clk);
    spur = 1'b0;
    repeat (6) @(negedge clk);
    n_checks++; if (bytes.size() !== 0) begin n_fail++; $display("FAIL spurious_tx got %0d bytes exp 0", bytes.size()); end
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL spurious_busy got %b exp 0", busy); end
    n_checks++; if (fd_cnt !== 0) begin n_fail++; $display("FAIL spurious_done got %0d exp 0", fd_cnt); end
  endtask

`ifdef UART_FRAME_CHECKSUM_EN
  task automatic test_checksum();
    int t0;
    bit ok;
    for (int k = 0; k < N_CH; k++) smp[k] = '0;
    smp[0] = 12'h0AB;
    load_samples(); clear_mon();
    pulse_start(t0);
    wait_fd(1, 600, ok);
    repeat (3) @(negedge clk);
    n_checks++; if (!ok || bytes.size() !== 41) begin n_fail++; $display("FAIL checksum_len got %0d exp 41", bytes.size()); end
    // XOR of index bytes 0x00..0x0C is 0x0C; ch0 MSB byte is 0x00, LSB 0xAB -> 0xA7
    n_checks++; if (bytes[40] !== 8'hA7) begin n_fail++; $display("FAIL checksum_byte got %h exp a7", bytes[40]); end
    n_checks++; if (bytes[3] !== 8'hAB) begin n_fail++; $display("FAIL checksum_ch0_lsb got %h exp ab", bytes[3]); end
  endtask
`endif

  initial begin
    test_reset();
    test_frame();
    test_restart();
    test_snapshot();
    test_reset_mid();
    test_spurious();
`ifdef UART_FRAME_CHECKSUM_EN
    test_checksum();
`endif
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
